// File: rtl/branch_resolve_mlane_if.sv
// EX-to-IFU bundle for the multi-lane branch resolver: per-lane EX inputs on the
// master side, redirect/predictor-update/statistics results on the slave side.
interface branch_resolve_mlane_if #(
  parameter int LANES = 2,
  parameter int CNT_W = 32
);
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

  logic [LANES-1:0]    ex_valid;
  logic [32*LANES-1:0] ex_pc;
  logic [LANES-1:0]    ex_is_branch;
  logic [LANES-1:0]    ex_is_jr;
  logic [LANES-1:0]    ex_is_j_imme;
  logic [4*LANES-1:0]  ex_branch_sel;
  logic [32*LANES-1:0] ex_rs_data;
  logic [32*LANES-1:0] ex_rt_data;
  logic [LANES-1:0]    ex_pred_taken;
  logic [32*LANES-1:0] ex_pred_target;
  logic [32*LANES-1:0] ex_act_target;
  logic                redirect_ack;

  logic                flush_req;
  logic [LW-1:0]       flush_lane;
  logic [31:0]         flush_target;
  logic [LANES-1:0]    upd_valid;
  logic [32*LANES-1:0] upd_pc;
  logic [32*LANES-1:0] upd_target;
  logic [LANES-1:0]    upd_taken;
  logic                busy;
  logic [CNT_W-1:0]    branch_cnt;
  logic [CNT_W-1:0]    mispred_cnt;

  modport master (
    output ex_valid, ex_pc, ex_is_branch, ex_is_jr, ex_is_j_imme, ex_branch_sel,
           ex_rs_data, ex_rt_data, ex_pred_taken, ex_pred_target, ex_act_target,
           redirect_ack,
    input  flush_req, flush_lane, flush_target, upd_valid, upd_pc, upd_target,
           upd_taken, busy, branch_cnt, mispred_cnt
  );

  modport slave (
    input  ex_valid, ex_pc, ex_is_branch, ex_is_jr, ex_is_j_imme, ex_branch_sel,
           ex_rs_data, ex_rt_data, ex_pred_taken, ex_pred_target, ex_act_target,
           redirect_ack,
    output flush_req, flush_lane, flush_target, upd_valid, upd_pc, upd_target,
           upd_taken, busy, branch_cnt, mispred_cnt
  );
endinterface

// File: rtl/branch_resolve_mlane.sv
// Resolves up to LANES branches per cycle, registers a held redirect for the
// oldest mispredicting lane, and emits predictor updates plus saturating stats.
module branch_resolve_mlane #(
  parameter int LANES = 2,
  parameter int CNT_W = 32
) (
  input logic clk,
  input logic rst,
  branch_resolve_mlane_if.slave bus
);
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

  localparam logic [3:0] BRANCH_SEL_BEQ    = 4'd1;
  localparam logic [3:0] BRANCH_SEL_BNE    = 4'd2;
  localparam logic [3:0] BRANCH_SEL_BGEZ   = 4'd3;
  localparam logic [3:0] BRANCH_SEL_BGTZ   = 4'd4;
  localparam logic [3:0] BRANCH_SEL_BLEZ   = 4'd5;
  localparam logic [3:0] BRANCH_SEL_BLTZ   = 4'd6;
  localparam logic [3:0] BRANCH_SEL_BGEZAL = 4'd7;
  localparam logic [3:0] BRANCH_SEL_BLTZAL = 4'd8;
  localparam logic [3:0] BRANCH_SEL_BAL    = 4'd9;

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t              r_state, w_nextState;
  logic [LANES-1:0]    w_jmp, w_actTaken, w_mis, w_updMask;
  logic                w_hasWin, w_accept, w_startFlush, w_endFlush;
  logic [LW-1:0]       w_winLane;
  logic [31:0]         w_winTarget;
  logic [CNT_W-1:0]    w_branchInc;

  logic                r_flushReq;
  logic [LW-1:0]       r_flushLane;
  logic [31:0]         r_flushTarget;
  logic [LANES-1:0]    r_updValid, r_updTaken;
  logic [32*LANES-1:0] r_updPc, r_updTarget;
  logic [CNT_W-1:0]    r_branchCnt, r_mispredCnt;

  function automatic logic [CNT_W-1:0] satAdd(input logic [CNT_W-1:0] a,
                                              input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  for (genvar g = 0; g < LANES; g++) begin : gLane
    logic signed [31:0] w_rs, w_rt;
    logic               w_cond;
    assign w_rs = bus.ex_rs_data[32*g +: 32];
    assign w_rt = bus.ex_rt_data[32*g +: 32];

    always_comb begin
      w_cond = 1'b0;
      case (bus.ex_branch_sel[4*g +: 4])
        BRANCH_SEL_BEQ:                     w_cond = (w_rs == w_rt);
        BRANCH_SEL_BNE:                     w_cond = (w_rs != w_rt);
        BRANCH_SEL_BGEZ, BRANCH_SEL_BGEZAL: w_cond = (w_rs >= 0);
        BRANCH_SEL_BGTZ:                    w_cond = (w_rs > 0);
        BRANCH_SEL_BLEZ:                    w_cond = (w_rs <= 0);
        BRANCH_SEL_BLTZ, BRANCH_SEL_BLTZAL: w_cond = (w_rs < 0);
        BRANCH_SEL_BAL:                     w_cond = 1'b1;
        default:                            w_cond = 1'b0;
      endcase
    end

    assign w_actTaken[g] = bus.ex_is_jr[g] | bus.ex_is_j_imme[g] | (bus.ex_is_branch[g] & w_cond);
    assign w_jmp[g]      = bus.ex_valid[g] & (bus.ex_is_branch[g] | bus.ex_is_jr[g] | bus.ex_is_j_imme[g]);
    assign w_mis[g]      = w_jmp[g] & ((bus.ex_pred_taken[g] != w_actTaken[g]) |
                           (w_actTaken[g] & (bus.ex_pred_target[32*g +: 32] != bus.ex_act_target[32*g +: 32])));
  end

  // Walk lanes oldest-first; everything younger than the first mispredict is killed.
  always_comb begin
    w_hasWin    = 1'b0;
    w_winLane   = '0;
    w_winTarget = '0;
    w_updMask   = '0;
    w_branchInc = '0;
    for (int i = 0; i < LANES; i++) begin
      if (!w_hasWin) begin
        w_updMask[i] = w_jmp[i];
        w_branchInc  = w_branchInc + CNT_W'(w_jmp[i]);
        if (w_mis[i]) begin
          w_hasWin    = 1'b1;
          w_winLane   = LW'(i);
          w_winTarget = w_actTaken[i] ? bus.ex_act_target[32*i +: 32]
                                      : bus.ex_pc[32*i +: 32] + 32'd8;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_hasWin) w_nextState = FLUSH;
      FLUSH:   if (bus.redirect_ack) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    w_accept     = (r_state == IDLE);
    w_startFlush = w_accept & w_hasWin;
    w_endFlush   = (r_state == FLUSH) & bus.redirect_ack;
  end

  // EX inputs are only consumed in IDLE; the redirect fields freeze while FLUSH waits for ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flushReq    <= 1'b0;
      r_flushLane   <= '0;
      r_flushTarget <= '0;
      r_updValid    <= '0;
      r_updTaken    <= '0;
      r_updPc       <= '0;
      r_updTarget   <= '0;
      r_branchCnt   <= '0;
      r_mispredCnt  <= '0;
    end else begin
      r_updValid <= w_accept ? w_updMask : '0;
      if (w_accept) begin
        r_updPc     <= bus.ex_pc;
        r_updTarget <= bus.ex_act_target;
        r_updTaken  <= w_actTaken;
        r_branchCnt <= satAdd(r_branchCnt, w_branchInc);
      end
      if (w_startFlush) begin
        r_flushReq    <= 1'b1;
        r_flushLane   <= w_winLane;
        r_flushTarget <= w_winTarget;
        r_mispredCnt  <= satAdd(r_mispredCnt, CNT_W'(1));
      end else if (w_endFlush) begin
        r_flushReq <= 1'b0;
      end
    end
  end

  assign bus.flush_req    = r_flushReq;
  assign bus.flush_lane   = r_flushLane;
  assign bus.flush_target = r_flushTarget;
  assign bus.upd_valid    = r_updValid;
  assign bus.upd_pc       = r_updPc;
  assign bus.upd_target   = r_updTarget;
  assign bus.upd_taken    = r_updTaken;
  assign bus.busy         = (r_state == FLUSH);
  assign bus.branch_cnt   = r_branchCnt;
  assign bus.mispred_cnt  = r_mispredCnt;
endmodule

// File: doc/branch_resolve_mlane.md
# branch_resolve_mlane

Multi-lane successor to the single-lane execute-stage branch checker. It resolves up to `LANES` jump/branch instructions per cycle in EX, selects the oldest mispredicting lane, and registers a redirect request that is held until fetch acknowledges it. It also emits registered predictor-update records and saturating branch/mispredict statistics counters. It sits between the EX stage of each issue lane and the IFU redirect and predictor-update ports.

## Interface
- `LANES`, 2, number of EX lanes resolved per cycle; lane 0 is the oldest in program order.
- `CNT_W`, 32, width of each statistics counter.
- `clk` input 1: the single clock.
- `rst` input 1: asynchronous, active-high reset.
- `ex_valid` input `LANES`: lane holds a live instruction.
- `ex_pc` input `32*LANES`: PC of each lane's instruction.
- `ex_is_branch`, `ex_is_jr`, `ex_is_j_imme` input `LANES` each: instruction class.
- `ex_branch_sel` input `4*LANES`: `BRANCH_SEL_*` code from the shared exu branch definitions.
- `ex_rs_data`, `ex_rt_data` input `32*LANES`: operands.
- `ex_pred_taken` input `LANES`; `ex_pred_target`, `ex_act_target` input `32*LANES`.
- `redirect_ack` input 1: fetch has accepted the redirect.
- `flush_req` output 1: registered redirect request, held until acknowledged.
- `flush_lane` output `$clog2(LANES)` (min 1): lane that mispredicted.
- `flush_target` output 32: correct next-fetch address.
- `upd_valid` output `LANES`: registered predictor-update strobes.
- `upd_pc`, `upd_target` output `32*LANES`; `upd_taken` output `LANES`.
- `busy` output 1: high in the FLUSH state.
- `branch_cnt`, `mispred_cnt` output `CNT_W` each: saturating counters.

## Operation
- Per lane, combinational:
  - `jmp = valid & (is_branch | is_jr | is_j_imme)`.
  - Conditions, with rs and rt taken as signed 32-bit values:
    - BEQ: rs == rt.
    - BNE: rs != rt.
    - BGEZ and BGEZAL: rs >= 0.
    - BGTZ: rs > 0.
    - BLEZ: rs <= 0.
    - BLTZ and BLTZAL: rs < 0.
    - BAL: always true.
    - Any other code: not taken.
  - `act_taken = is_jr | is_j_imme | (is_branch & cond)`.
  - `mis = jmp & (pred_taken != act_taken | act_taken & pred_target != act_target)`.
- Winner is the lowest-index lane with `mis` set.
  - Lanes above the winner are killed: no update and no count.
  - The winner and older lanes are retained.
- Redirect target:
  - `act_target` if the winner has `act_taken` set.
  - Otherwise `ex_pc + 8` (skips the delay slot), modulo 2^32.
- FSM states are IDLE and FLUSH.
- IDLE:
  - Retained jmp lanes register `upd_*` for one cycle and increment `branch_cnt` by their count.
  - If a winner exists, register `flush_req=1`, `flush_lane`, and `flush_target`, increment `mispred_cnt` by 1, and go to FLUSH.
- FLUSH:
  - All `ex_*` inputs are ignored: no updates, no counting, no new detection.
  - `flush_req`, `flush_lane`, and `flush_target` hold stable.
  - On `redirect_ack=1`, go to IDLE and drop `flush_req` next cycle.
- `redirect_ack` in IDLE is ignored.
- Counters saturate at 2^CNT_W-1 and never wrap.
  - The `branch_cnt` increment is the popcount of retained lanes, clamped at saturation.

## Timing
- Reset (async assert, value visible immediately):
  - State is IDLE.
  - `flush_req`, `upd_valid`, and `busy` are 0.
  - `flush_lane`, `flush_target`, `upd_pc`, `upd_target`, `upd_taken`, and both counters are 0.
- Reset during FLUSH aborts the redirect: `flush_req` drops at once.
- Latency is 1 cycle from the EX inputs to `flush_req` and `upd_valid`. No combinational path exists from `ex_*` to any output.
- `upd_valid` is a single-cycle pulse per resolved cycle. It is deasserted in every FLUSH cycle, including the cycle `redirect_ack` is sampled.
- `flush_req` stays high for at least 1 cycle. Ack on the first FLUSH cycle means `flush_req` is high for exactly 1 cycle.
- `busy` equals `(state == FLUSH)` and is registered.
- The first EX cycle accepted after a flush is the cycle after the ack is sampled.

## Test plan
- LANES=2, lane0 BEQ with rs=rt=5, pred_taken=1, pred_target=act_target=0x1000 -> next cycle `upd_valid`=01 and `upd_taken`[0]=1; `flush_req`=0; `branch_cnt`=1.
- Lane0 BNE with rs=rt=3, pred_taken=1, ex_pc=0x400 -> next cycle `flush_req`=1, `flush_lane`=0, `flush_target`=0x408, `mispred_cnt`=1; held 3 cycles with ack=0, then ack=1 -> `flush_req`=0 the cycle after.
- Both lanes mispredict: lane0 JR with pred_taken=0 and act_target=0x2000; lane1 BLTZ -> `flush_lane`=0, `flush_target`=0x2000, `upd_valid`=01, `branch_cnt`+=1.
- Lane0 BGTZ with rs=0 predicted not-taken (correct), lane1 J predicted taken with wrong target 0x300 vs act_target 0x340 -> `flush_lane`=1, `flush_target`=0x340, `upd_valid`=11.
- In FLUSH, drive mispredicting inputs for 4 cycles -> counters unchanged, `upd_valid`=0, `flush_target` stable; assert `rst` mid-FLUSH -> all outputs 0 immediately.
- CNT_W=4, 20 correct BAL cycles on both lanes -> `branch_cnt` saturates at 15 with no wrap.
